// File: rtl/pc_stack_unit.sv
// Program counter with increment, absolute jump, signed relative branch and CALL/RET
// through a register-array return-address stack; all outputs registered, one-cycle latency.
module pc_stack_unit #(
  parameter int              AW           = 8,
  parameter int              OW           = 4,
  parameter int              DEPTH        = 4,
  parameter logic [AW-1:0]   RESET_VECTOR = '0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      PCEN,
  input  logic                      LOAD,
  input  logic                      BRANCH,
  input  logic                      CALL,
  input  logic                      RET,
  input  logic [AW-1:0]             IN,
  input  logic [OW-1:0]             OFFSET,
  output logic [AW-1:0]             A,
  output logic [$clog2(DEPTH):0]    DEPTH_CNT,
  output logic                      OVF,
  output logic                      UNF
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [AW-1:0] ras [DEPTH];
  logic [AW-1:0] a_nxt;
  logic [AW-1:0] a_inc;
  logic [AW-1:0] br_tgt;
  logic [CW-1:0] cnt_nxt;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;
  logic          push;
  logic          ovf_set;
  logic          unf_set;
  logic          full;
  logic          empty;

  assign a_inc    = A + AW'(1);
  // Size cast of a signed operand sign-extends OFFSET up to AW bits.
  assign br_tgt   = A + AW'($signed(OFFSET));
  assign full     = (DEPTH_CNT == CW'(DEPTH));
  assign empty    = (DEPTH_CNT == '0);
  assign push_idx = DEPTH_CNT[IW-1:0];
  assign top_idx  = push_idx - IW'(1);

  always_comb begin
    a_nxt   = A;
    cnt_nxt = DEPTH_CNT;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (RET) begin
      if (!empty) begin
        a_nxt   = ras[top_idx];
        cnt_nxt = DEPTH_CNT - CW'(1);
      end else begin
        unf_set = 1'b1;
      end
    end else if (CALL) begin
      if (!full) begin
        push    = 1'b1;
        a_nxt   = IN;
        cnt_nxt = DEPTH_CNT + CW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (LOAD) begin
      a_nxt = IN;
    end else if (BRANCH) begin
      a_nxt = br_tgt;
    end else if (PCEN) begin
      a_nxt = a_inc;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      A         <= RESET_VECTOR;
      DEPTH_CNT <= '0;
      OVF       <= 1'b0;
      UNF       <= 1'b0;
    end else begin
      A         <= a_nxt;
      DEPTH_CNT <= cnt_nxt;
      OVF       <= OVF | ovf_set;
      UNF       <= UNF | unf_set;
    end
  end

  // Stack storage needs no reset: entries above DEPTH_CNT are never read.
  always_ff @(posedge CLK) begin
    if (push) begin
      ras[push_idx] <= a_inc;
    end
  end

endmodule
